uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx_cfg.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states,
// parity-mode codes and data-length decode.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // cfg_parity codes; the fourth code (2'b11) behaves as none
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  // cfg_data_bits codes
  localparam logic [1:0] DLEN_5 = 2'd0;
  localparam logic [1:0] DLEN_6 = 2'd1;
  localparam logic [1:0] DLEN_7 = 2'd2;
  localparam logic [1:0] DLEN_8 = 2'd3;

  function automatic logic [3:0] data_last_idx(input logic [1:0] dlen);
    case (dlen)
      DLEN_5:  return 4'd4;
      DLEN_6:  return 4'd5;
      DLEN_7:  return 4'd6;
      DLEN_8:  return 4'd7;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic par_enabled(input logic [1:0] mode);
    return !(mode == PAR_NONE || mode == PAR_RSVD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud_tick pulses while enabled and strobes bit_end on the tick
// that completes one serial bit period of OVERSAMPLE ticks.
`timescale 1ns/1ps
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic baud_tick,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q;

  assign bit_end = en && baud_tick && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (baud_tick) begin
      cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5-8 data bits, 1/2 stop bits) with a
// one-entry holding register. Parity support is built only with UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_MAX   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                baud_tick,
  input  logic                i_valid,
  input  logic [DATA_MAX-1:0] din,
  output logic                o_ready,
  input  logic [1:0]          cfg_data_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  output logic                o_tx,
  output logic                o_tx_busy,
  output logic                o_tx_done
);

  tx_state_t           state_q, state_d;
  logic                hold_full_q;
  logic [DATA_MAX-1:0] hold_q;
  logic [DATA_MAX-1:0] shreg_q;
  logic [3:0]          bit_idx_q;
  logic [3:0]          last_idx_q;
  logic                stop2_q;
  logic                stop_idx_q;
  logic                done_q;
  logic                bit_end;
  logic                load;
  logic                frame_end;
  logic                accept;
  logic                timer_en;

  assign o_ready   = !hold_full_q;
  assign accept    = i_valid && o_ready;
  assign o_tx_busy = (state_q != ST_IDLE);
  assign o_tx_done = done_q;
  assign timer_en  = (state_q != ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (timer_en),
    .baud_tick(baud_tick),
    .bit_end  (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic                par_en_q;
  logic                par_bit_q;
  logic [DATA_MAX-1:0] data_mask;

  always_comb begin
    data_mask = '0;
    for (int unsigned i = 0; i < DATA_MAX; i++) begin
      data_mask[i] = (i <= 32'(data_last_idx(cfg_data_bits)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load) begin
      par_en_q  <= par_enabled(cfg_parity);
      par_bit_q <= (^(hold_q & data_mask)) ^ (cfg_parity == PAR_ODD);
    end
  end
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
`endif

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_idx_q == last_idx_q) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // a byte waiting in the holding register chains straight into START
        if (bit_end && stop_idx_q == stop2_q) begin
          frame_end = 1'b1;
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // load only fires with the holding register full, so it never collides with accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      last_idx_q  <= '0;
      stop2_q     <= 1'b0;
      stop_idx_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= frame_end;
      if (load) begin
        hold_full_q <= 1'b0;
        shreg_q     <= hold_q;
        last_idx_q  <= data_last_idx(cfg_data_bits);
        stop2_q     <= cfg_stop2;
        bit_idx_q   <= '0;
        stop_idx_q  <= 1'b0;
      end else begin
        if (accept) begin
          hold_q      <= din;
          hold_full_q <= 1'b1;
        end
        if (bit_end && state_q == ST_DATA) begin
          shreg_q   <= shreg_q >> 1;
          bit_idx_q <= (state_d == ST_DATA) ? bit_idx_q + 4'd1 : 4'd0;
        end
        if (bit_end && state_q == ST_STOP) begin
          stop_idx_q <= (state_d == ST_STOP);
        end
      end
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (state_q)
      ST_START: o_tx = 1'b0;
      ST_DATA:  o_tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: o_tx = par_bit_q;
`endif
      default:  o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table-driven frames, directed corner sequences and
// randomized traffic checked against a tick-level line model.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int unsigned OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] cfg_data_bits = 2'd3;
  logic [1:0] cfg_parity = 2'd0;
  logic       cfg_stop2 = 1'b0;
  logic       o_ready, o_tx, o_tx_busy, o_tx_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bit exp_q[$];
  bit cap_q[$];
  int unsigned done_hi = 0, done_rise = 0, busy_fall = 0, idle_bad = 0;
  logic done_prev = 1'b0, busy_prev = 1'b0;

  typedef struct {
    logic [7:0]  din;
    logic [1:0]  db;
    logic [1:0]  pm;
    logic        s2;
    bit          has_par;
    int unsigned nb_par;
    int unsigned nb_nopar;
    logic        exp_par;
  } vec_t;

  uart_tx_cfg #(
    .OVERSAMPLE(OS),
    .DATA_MAX  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .i_valid      (i_valid),
    .din          (din),
    .o_ready      (o_ready),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .o_tx         (o_tx),
    .o_tx_busy    (o_tx_busy),
    .o_tx_done    (o_tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      baud_tick = ($urandom_range(0, 1) == 1);
    end
  end

  // line sampled once per baud tick while a frame is in progress
  always @(negedge clk) begin
    if (baud_tick && o_tx_busy) cap_q.push_back(o_tx);
    if (o_tx_done) done_hi <= done_hi + 1;
    if (o_tx_done && !done_prev) done_rise <= done_rise + 1;
    if (rst_n && !o_tx_busy && !o_tx) idle_bad <= idle_bad + 1;
    if (busy_prev && !o_tx_busy) busy_fall <= busy_fall + 1;
    done_prev <= o_tx_done;
    busy_prev <= o_tx_busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // expected line value for every baud tick of one frame
  function automatic void model_frame(input logic [7:0] d, input logic [1:0] db,
                                      input logic [1:0] pm, input logic s2);
    int unsigned n;
    bit bits[$];
    bit p;
    n = 32'd5 + {30'd0, db};
    bits.push_back(1'b0);
    for (int unsigned i = 0; i < n; i++) bits.push_back(d[i]);
    if (PAR_ON && (pm == 2'b01 || pm == 2'b10)) begin
      p = 1'b0;
      for (int unsigned i = 0; i < n; i++) p = p ^ d[i];
      if (pm == 2'b10) p = ~p;
      bits.push_back(p);
    end
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) repeat (OS) exp_q.push_back(bits[k]);
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int unsigned n;
    n = 0;
    while (!o_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_wait", 32'(o_ready), 32'd1);
    if (!o_ready) return;
    din = d;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int unsigned base, input int unsigned ticks, input string tag);
    int unsigned n;
    n = 0;
    while ((32'(cap_q.size()) - base) < ticks && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tick_wait"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_done(input int unsigned base, input string tag);
    int unsigned n, lim;
    n = 0;
    lim = 32'(exp_q.size()) * 8 + 500;
    while (!(((32'(cap_q.size()) - base) >= 32'(exp_q.size())) && !o_tx_busy && o_ready)
           && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_wait"}, 32'(n < lim), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_stream(input int unsigned base, input string tag);
    int unsigned got, want, bad, m;
    got  = 32'(cap_q.size()) - base;
    want = 32'(exp_q.size());
    bad  = 0;
    m    = (got < want) ? got : want;
    check({tag, "_ticks"}, got, want);
    for (int unsigned i = 0; i < m; i++) if (cap_q[base + i] != exp_q[i]) bad++;
    check({tag, "_wrong_ticks"}, bad, 32'd0);
  endtask

  initial begin
    vec_t        vt[5];
    int unsigned base, d0, h0, f0, c0, ib0, n, nb, nfr;
    logic [7:0]  rd;
    logic [1:0]  rdb, rpm;
    logic        rs2;

    vt[0] = '{8'h55, 2'd3, 2'b00, 1'b0, 1'b0, 10, 10, 1'b0};
    vt[1] = '{8'hA3, 2'd2, 2'b01, 1'b0, 1'b1, 10,  9, 1'b1};
    vt[2] = '{8'h1F, 2'd0, 2'b10, 1'b1, 1'b1,  9,  8, 1'b0};
    vt[3] = '{8'hC6, 2'd1, 2'b11, 1'b1, 1'b0,  9,  9, 1'b0};
    vt[4] = '{8'h80, 2'd3, 2'b01, 1'b1, 1'b1, 12, 11, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(o_tx), 32'd1);
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_busy", 32'(o_tx_busy), 32'd0);
    check("reset_done", 32'(o_tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      cfg_data_bits = vt[v].db;
      cfg_parity    = vt[v].pm;
      cfg_stop2     = vt[v].s2;
      base = 32'(cap_q.size());
      d0 = done_rise;
      h0 = done_hi;
      exp_q.delete();
      model_frame(vt[v].din, vt[v].db, vt[v].pm, vt[v].s2);
      send_byte(vt[v].din);
      wait_done(base, "vec");
      compare_stream(base, "vec_model");
      n  = 32'd5 + {30'd0, vt[v].db};
      nb = PAR_ON ? vt[v].nb_par : vt[v].nb_nopar;
      check("vec_frame_len", 32'(cap_q.size()) - base, nb * OS);
      if (PAR_ON && vt[v].has_par)
        check("vec_parity_bit", 32'(cap_q[base + (1 + n) * OS + OS / 2]), 32'(vt[v].exp_par));
      check("vec_done_pulses", done_rise - d0, 32'd1);
      check("vec_done_width", done_hi - h0, 32'd1);
    end

    // back-to-back 00 then FF, second byte offered mid-frame
    cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    base = 32'(cap_q.size()); d0 = done_rise; f0 = busy_fall;
    exp_q.delete();
    model_frame(8'h00, 2'd3, 2'b00, 1'b0);
    model_frame(8'hFF, 2'd3, 2'b00, 1'b0);
    send_byte(8'h00);
    wait_ticks(base, 3 * OS, "b2b");
    send_byte(8'hFF);
    wait_done(base, "b2b");
    compare_stream(base, "b2b_model");
    check("b2b_busy_falls", busy_fall - f0, 32'd1);
    check("b2b_done_pulses", done_rise - d0, 32'd2);

    // offers while the holding register is full must be dropped
    base = 32'(cap_q.size()); d0 = done_rise;
    exp_q.delete();
    model_frame(8'h5A, 2'd3, 2'b00, 1'b0);
    model_frame(8'hC3, 2'd3, 2'b00, 1'b0);
    send_byte(8'h5A);
    wait_ticks(base, 2 * OS, "drop");
    send_byte(8'hC3);
    @(negedge clk);
    check("drop_ready_low", 32'(o_ready), 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (!o_ready) begin
        din = 8'h77;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    wait_done(base, "drop");
    compare_stream(base, "drop_model");
    check("drop_done_pulses", done_rise - d0, 32'd2);

    // reset in the middle of data bit 3
    base = 32'(cap_q.size());
    exp_q.delete();
    send_byte(8'hF0);
    wait_ticks(base, 4 * OS + OS / 2, "rst");
    check("rst_pre_tx_bit3", 32'(o_tx), 32'd0);
    d0 = done_rise;
    ib0 = idle_bad;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(o_tx), 32'd1);
    check("rst_async_ready", 32'(o_ready), 32'd1);
    check("rst_async_busy", 32'(o_tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = 32'(cap_q.size());
    repeat (200) @(negedge clk);
    check("rst_no_done", done_rise - d0, 32'd0);
    check("rst_no_more_bits", 32'(cap_q.size()) - c0, 32'd0);
    check("rst_line_high", idle_bad - ib0, 32'd0);

    // randomized traffic with cfg scrambled while frames are in flight
    base = 32'(cap_q.size()); d0 = done_rise; nfr = 0;
    exp_q.delete();
    for (int it = 0; it < 24; it++) begin
      rd  = 8'($urandom);
      rdb = 2'($urandom_range(0, 3));
      rpm = 2'($urandom_range(0, 3));
      rs2 = 1'($urandom_range(0, 1));
      cfg_data_bits = rdb; cfg_parity = rpm; cfg_stop2 = rs2;
      model_frame(rd, rdb, rpm, rs2);
      send_byte(rd);
      nfr++;
      n = 0;
      while (!o_ready && n < 20000) begin
        @(negedge clk);
        n++;
      end
      repeat ($urandom_range(0, 60)) begin
        @(negedge clk);
        cfg_data_bits = 2'($urandom_range(0, 3));
        cfg_parity    = 2'($urandom_range(0, 3));
        cfg_stop2     = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        n = 0;
        while (o_tx_busy && n < 20000) begin
          @(negedge clk);
          n++;
        end
      end
    end
    wait_done(base, "rand");
    compare_stream(base, "rand_model");
    check("rand_done_pulses", done_rise - d0, nfr);
    check("done_one_clk", done_hi, done_rise);
    check("idle_line_high", idle_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
